// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch: clock rate, debounce timing
// and the button debouncer's state encoding.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    DB_S_LOW      = 2'b00,
    DB_S_LOW_CHK  = 2'b01,
    DB_S_HIGH     = 2'b10,
    DB_S_HIGH_CHK = 2'b11
  } db_state_t;

  localparam int CLK_FREQ_HZ = 100_000_000;
  localparam int DEBOUNCE_MS = 10;

  localparam int DB_STABLE_CYCLES =
    CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Reusable for any async input crossing into clk.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_param_err
    $error("bit_synchronizer: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button: synchronise, then accept a level
// change only after it has held for STABLE_CYCLES clocks.
module button_debouncer
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = DB_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_clean,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < 2 || STABLE_CYCLES < 1) begin : g_param_err
    $error("button_debouncer: bad SYNC_STAGES/STABLE_CYCLES");
  end

  logic             btn_sync;
  db_state_t        state;
  db_state_t        state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             clean_nx;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clean_nx = btn_clean;
    case (state)
      DB_S_LOW: begin
        if (btn_sync) begin
          state_nx = DB_S_LOW_CHK;
          cnt_nx   = '0;
        end
      end
      DB_S_LOW_CHK: begin
        if (!btn_sync) begin
          state_nx = DB_S_LOW;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = DB_S_HIGH;
          clean_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DB_S_HIGH: begin
        if (!btn_sync) begin
          state_nx = DB_S_HIGH_CHK;
          cnt_nx   = '0;
        end
      end
      DB_S_HIGH_CHK: begin
        if (btn_sync) begin
          state_nx = DB_S_HIGH;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = DB_S_LOW;
          clean_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = DB_S_LOW;
        cnt_nx   = '0;
        clean_nx = 1'b0;
      end
    endcase
  end

  // busy follows the next state so it lines up with state itself
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DB_S_LOW;
      cnt       <= '0;
      btn_clean <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      btn_clean <= clean_nx;
      busy      <= (state_nx == DB_S_LOW_CHK) ||
                   (state_nx == DB_S_HIGH_CHK);
    end
  end

endmodule
